// File: rtl/product_accumulator_pkg.sv
// Shared definitions for the product accumulator: FSM state encoding and
// the default product width coming from the upstream multiplier.
package product_accumulator_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  localparam int DEF_PROD_W = 8;

endpackage

// File: rtl/product_accumulator.sv
// Sums frames of COUNT products from the multiplier into a wide accumulator
// and presents each frame sum (with sticky overflow) on a valid/ready output.
module product_accumulator
  import product_accumulator_pkg::*;
#(
  parameter int PROD_W = DEF_PROD_W,
  parameter int ACC_W  = 12,
  parameter int COUNT  = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [PROD_W-1:0] in_prod_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [ACC_W-1:0]  out_sum_o,
  output logic              out_ovf_o,
  output logic              busy_o
);

  localparam int CNT_W = $clog2(COUNT + 1);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [ACC_W-1:0]   sum_q, sum_d;
  logic               sumOvf_q, sumOvf_d;

  logic               accept;
  logic [ACC_W:0]     accNext;

  assign accept  = in_valid_i && (state_q == ACCUM);
  // The extra top bit of accNext is the carry out of the accumulator width.
  assign accNext = {1'b0, acc_q} + (ACC_W + 1)'(in_prod_i);

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    sum_d    = sum_q;
    sumOvf_d = sumOvf_q;

    if (clr_i) begin
      state_d = ACCUM;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (accept) begin
            acc_d = accNext[ACC_W-1:0];
            ovf_d = ovf_q | accNext[ACC_W];
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(COUNT - 1)) begin
              sum_d    = accNext[ACC_W-1:0];
              sumOvf_d = ovf_q | accNext[ACC_W];
              state_d  = HOLD;
            end
          end
        end
        HOLD: begin
          if (out_ready_i) begin
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            state_d = ACCUM;
          end
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ACCUM;
      acc_q    <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      sum_q    <= '0;
      sumOvf_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      sum_q    <= sum_d;
      sumOvf_q <= sumOvf_d;
    end
  end

  // Every output comes from a register or the state, never from an input.
  assign in_ready_o  = (state_q == ACCUM);
  assign out_valid_o = (state_q == HOLD);
  assign out_sum_o   = (state_q == HOLD) ? sum_q : '0;
  assign out_ovf_o   = (state_q == HOLD) ? sumOvf_q : 1'b0;
  assign busy_o      = (cnt_q != '0) || (state_q == HOLD);

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: default, narrow-accumulator and
// single-product-frame instances driven from vector tables and short sequences.
module tb_product_accumulator;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int nCompared = 0;
  int nMismatched = 0;

  // Default instance
  logic       clr0 = 0, inValid0 = 0, outReady0 = 0;
  logic [7:0] inProd0 = 0;
  logic       inReady0, outValid0, outOvf0, busy0;
  logic [11:0] outSum0;

  product_accumulator dut0 (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr0),
    .in_valid_i(inValid0), .in_ready_o(inReady0), .in_prod_i(inProd0),
    .out_valid_o(outValid0), .out_ready_i(outReady0),
    .out_sum_o(outSum0), .out_ovf_o(outOvf0), .busy_o(busy0)
  );

  // Narrow accumulator to exercise wrap and sticky overflow
  logic       clr1 = 0, inValid1 = 0, outReady1 = 0;
  logic [7:0] inProd1 = 0;
  logic       inReady1, outValid1, outOvf1, busy1;
  logic [8:0] outSum1;

  product_accumulator #(.ACC_W(9)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr1),
    .in_valid_i(inValid1), .in_ready_o(inReady1), .in_prod_i(inProd1),
    .out_valid_o(outValid1), .out_ready_i(outReady1),
    .out_sum_o(outSum1), .out_ovf_o(outOvf1), .busy_o(busy1)
  );

  // One product per frame
  logic       clr2 = 0, inValid2 = 0, outReady2 = 0;
  logic [7:0] inProd2 = 0;
  logic       inReady2, outValid2, outOvf2, busy2;
  logic [11:0] outSum2;

  product_accumulator #(.COUNT(1)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr2),
    .in_valid_i(inValid2), .in_ready_o(inReady2), .in_prod_i(inProd2),
    .out_valid_o(outValid2), .out_ready_i(outReady2),
    .out_sum_o(outSum2), .out_ovf_o(outOvf2), .busy_o(busy2)
  );

  typedef struct {
    logic        v;
    logic [7:0]  p;
    logic        r;
    logic        c;
    logic        eRdy;
    logic        eVal;
    logic [11:0] eSum;
    logic        eOvf;
    logic        eBusy;
    logic        chkSum;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic v, logic [7:0] p, logic r, logic c,
                              logic eRdy, logic eVal, logic [11:0] eSum,
                              logic eOvf, logic eBusy, logic chkSum);
    vec_t x;
    x.v = v; x.p = p; x.r = r; x.c = c;
    x.eRdy = eRdy; x.eVal = eVal; x.eSum = eSum;
    x.eOvf = eOvf; x.eBusy = eBusy; x.chkSum = chkSum;
    return x;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t x);
    inValid0  = x.v;
    inProd0   = x.p;
    outReady0 = x.r;
    clr0      = x.c;
    tick();
  endtask

  initial begin
    // Back-to-back frame 36+12+35+49 = 132, one-cycle handshake
    vecs.push_back(mk(1, 36, 1, 0, 1, 0,   0, 0, 1, 1));
    vecs.push_back(mk(1, 12, 1, 0, 1, 0,   0, 0, 1, 1));
    vecs.push_back(mk(1, 35, 1, 0, 1, 0,   0, 0, 1, 1));
    vecs.push_back(mk(1, 49, 1, 0, 0, 1, 132, 0, 1, 1));
    vecs.push_back(mk(0,  0, 1, 0, 1, 0,   0, 0, 0, 0));
    // Output stall for 5 cycles with products offered during HOLD
    vecs.push_back(mk(1,  1, 0, 0, 1, 0,   0, 0, 1, 0));
    vecs.push_back(mk(1,  2, 0, 0, 1, 0,   0, 0, 1, 0));
    vecs.push_back(mk(1,  3, 0, 0, 1, 0,   0, 0, 1, 0));
    vecs.push_back(mk(1,  4, 0, 0, 0, 1,  10, 0, 1, 1));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(1, 99, 0, 0, 0, 1, 10, 0, 1, 1));
    vecs.push_back(mk(1, 99, 1, 0, 1, 0,   0, 0, 0, 0));
    vecs.push_back(mk(0,  0, 1, 0, 1, 0,   0, 0, 0, 0));
    // clr on the third accept drops 30; next frame 1+2+3+4 = 10
    vecs.push_back(mk(1, 10, 1, 0, 1, 0,   0, 0, 1, 0));
    vecs.push_back(mk(1, 20, 1, 0, 1, 0,   0, 0, 1, 0));
    vecs.push_back(mk(1, 30, 1, 1, 1, 0,   0, 0, 0, 0));
    vecs.push_back(mk(1,  1, 1, 0, 1, 0,   0, 0, 1, 0));
    vecs.push_back(mk(1,  2, 1, 0, 1, 0,   0, 0, 1, 0));
    vecs.push_back(mk(1,  3, 1, 0, 1, 0,   0, 0, 1, 0));
    vecs.push_back(mk(1,  4, 1, 0, 0, 1,  10, 0, 1, 1));
    vecs.push_back(mk(0,  0, 1, 0, 1, 0,   0, 0, 0, 0));
    // clr while holding discards the pending sum; fresh frame sums to 4
    vecs.push_back(mk(1,  5, 0, 0, 1, 0,   0, 0, 1, 0));
    vecs.push_back(mk(1,  5, 0, 0, 1, 0,   0, 0, 1, 0));
    vecs.push_back(mk(1,  5, 0, 0, 1, 0,   0, 0, 1, 0));
    vecs.push_back(mk(1,  5, 0, 0, 0, 1,  20, 0, 1, 1));
    vecs.push_back(mk(0,  0, 0, 1, 1, 0,   0, 0, 0, 0));
    vecs.push_back(mk(1,  1, 1, 0, 1, 0,   0, 0, 1, 0));
    vecs.push_back(mk(1,  1, 1, 0, 1, 0,   0, 0, 1, 0));
    vecs.push_back(mk(1,  1, 1, 0, 1, 0,   0, 0, 1, 0));
    vecs.push_back(mk(1,  1, 1, 0, 0, 1,   4, 0, 1, 1));
    vecs.push_back(mk(0,  0, 0, 0, 0, 1,   4, 0, 1, 1));

    // Reset state
    #12;
    checkOutput("reset inReady", 32'(inReady0), 1);
    checkOutput("reset outValid", 32'(outValid0), 0);
    checkOutput("reset outSum", 32'(outSum0), 0);
    checkOutput("reset outOvf", 32'(outOvf0), 0);
    checkOutput("reset busy", 32'(busy0), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("v%0d inReady", i), 32'(inReady0), 32'(vecs[i].eRdy));
      checkOutput($sformatf("v%0d outValid", i), 32'(outValid0), 32'(vecs[i].eVal));
      checkOutput($sformatf("v%0d busy", i), 32'(busy0), 32'(vecs[i].eBusy));
      if (vecs[i].chkSum) begin
        checkOutput($sformatf("v%0d outSum", i), 32'(outSum0), 32'(vecs[i].eSum));
        checkOutput($sformatf("v%0d outOvf", i), 32'(outOvf0), 32'(vecs[i].eOvf));
      end
    end

    // Asynchronous reset between edges while dut0 holds a sum of 4
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async rst outValid", 32'(outValid0), 0);
    checkOutput("async rst outSum", 32'(outSum0), 0);
    checkOutput("async rst inReady", 32'(inReady0), 1);
    checkOutput("async rst busy", 32'(busy0), 0);
    #3;
    rst_n = 1'b1;
    outReady0 = 1'b0;
    inValid0 = 1'b0;
    clr0 = 1'b0;
    tick();
    checkOutput("post rst inReady", 32'(inReady0), 1);
    checkOutput("post rst outValid", 32'(outValid0), 0);

    // ACC_W = 9: 4 x 225 = 900 wraps to 388 with overflow
    inValid1 = 1'b1;
    inProd1 = 8'd225;
    outReady1 = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    inValid1 = 1'b0;
    checkOutput("wrap outValid", 32'(outValid1), 1);
    checkOutput("wrap outSum", 32'(outSum1), 388);
    checkOutput("wrap outOvf", 32'(outOvf1), 1);
    outReady1 = 1'b1;
    tick();
    checkOutput("wrap handshake inReady", 32'(inReady1), 1);
    inValid1 = 1'b1;
    inProd1 = 8'd1;
    for (int i = 0; i < 4; i++) tick();
    inValid1 = 1'b0;
    checkOutput("after wrap outValid", 32'(outValid1), 1);
    checkOutput("after wrap outSum", 32'(outSum1), 4);
    checkOutput("after wrap outOvf", 32'(outOvf1), 0);
    tick();

    // COUNT = 1 with in_valid held: one result every two cycles
    inValid2 = 1'b1;
    outReady2 = 1'b1;
    inProd2 = 8'd6;
    tick();
    checkOutput("c1 first outValid", 32'(outValid2), 1);
    checkOutput("c1 first outSum", 32'(outSum2), 6);
    checkOutput("c1 first inReady", 32'(inReady2), 0);
    inProd2 = 8'd7;
    tick();
    checkOutput("c1 gap outValid", 32'(outValid2), 0);
    checkOutput("c1 gap inReady", 32'(inReady2), 1);
    tick();
    checkOutput("c1 second outValid", 32'(outValid2), 1);
    checkOutput("c1 second outSum", 32'(outSum2), 7);
    checkOutput("c1 second inReady", 32'(inReady2), 0);
    inValid2 = 1'b0;
    tick();
    checkOutput("c1 end inReady", 32'(inReady2), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
